// File: rtl/cola_buyer.sv
// Automated buyer that feeds coins from a latched wallet into a 2.5-yuan vending machine.
// Optional macro COLA_BUYER_DUAL_COIN_EN allows a simultaneous yuan+jiao insertion.
module cola_buyer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] yuan_cnt,
  input  logic [3:0] jiao_cnt,
  input  logic       out_cola,
  input  logic       out_coin,
  output logic       in_yuan,
  output logic       in_jiao,
  output logic       busy,
  output logic       done,
  output logic       got_cola,
  output logic       got_change,
  output logic       err,
  output logic [3:0] yuan_left,
  output logic [3:0] jiao_left,
  output logic [2:0] paid
);

  typedef enum logic [1:0] {S_IDLE, S_INSERT, S_WAIT, S_FIN} state_t;

  state_t     state_q, state_d;
  logic [3:0] yuan_q, yuan_d, jiao_q, jiao_d;
  logic [2:0] paid_q, paid_d;
  logic       cola_q, cola_d, change_q, change_d, err_q, err_d;
  logic       pick_yuan, pick_jiao;
  logic [2:0] need;
  logic [3:0] paid_sum;
  logic       dual_ok;
  logic       coin_bad;

  // Price is 5 half-yuan units; need is zero once fully paid.
  assign need = (paid_q >= 3'd5) ? 3'd0 : (3'd5 - paid_q);

`ifdef COLA_BUYER_DUAL_COIN_EN
  assign dual_ok = (need >= 3'd3) && (yuan_q != 4'd0) && (jiao_q != 4'd0);
`else
  assign dual_ok = 1'b0;
`endif

  // Change is expected exactly when the machine was overpaid by one unit.
  assign coin_bad = (out_coin && (paid_q != 3'd6)) || (!out_coin && (paid_q == 3'd6));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      yuan_q   <= 4'd0;
      jiao_q   <= 4'd0;
      paid_q   <= 3'd0;
      cola_q   <= 1'b0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      yuan_q   <= yuan_d;
      jiao_q   <= jiao_d;
      paid_q   <= paid_d;
      cola_q   <= cola_d;
      change_q <= change_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    yuan_d    = yuan_q;
    jiao_d    = jiao_q;
    paid_d    = paid_q;
    cola_d    = cola_q;
    change_d  = change_q;
    err_d     = err_q;
    pick_yuan = 1'b0;
    pick_jiao = 1'b0;
    paid_sum  = {1'b0, paid_q};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_INSERT;
          yuan_d   = yuan_cnt;
          jiao_d   = jiao_cnt;
          paid_d   = 3'd0;
          cola_d   = 1'b0;
          change_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_INSERT: begin
        if (dual_ok) begin
          pick_yuan = 1'b1;
          pick_jiao = 1'b1;
          paid_sum  = {1'b0, paid_q} + 4'd3;
        end else if ((need >= 3'd2) && (yuan_q != 4'd0)) begin
          pick_yuan = 1'b1;
          paid_sum  = {1'b0, paid_q} + 4'd2;
        end else if (jiao_q != 4'd0) begin
          pick_jiao = 1'b1;
          paid_sum  = {1'b0, paid_q} + 4'd1;
        end else if (yuan_q != 4'd0) begin
          pick_yuan = 1'b1;
          paid_sum  = {1'b0, paid_q} + 4'd2;
        end
        // Chosen counters are known non-zero, so the decrement cannot wrap.
        if (pick_yuan) yuan_d = yuan_q - 4'd1;
        if (pick_jiao) jiao_d = jiao_q - 4'd1;
        paid_d = (paid_sum > 4'd6) ? 3'd6 : paid_sum[2:0];
        if (pick_yuan || pick_jiao) begin
          state_d = S_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_WAIT: begin
        if (out_coin) change_d = 1'b1;
        if (coin_bad) err_d = 1'b1;
        if (paid_q >= 3'd5) begin
          if (out_cola) cola_d = 1'b1;
          else          err_d  = 1'b1;
          state_d = S_FIN;
        end else if (out_cola || coin_bad) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_INSERT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_yuan    = pick_yuan;
  assign in_jiao    = pick_jiao;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign got_cola   = cola_q;
  assign got_change = change_q;
  assign err        = err_q;
  assign yuan_left  = yuan_q;
  assign jiao_left  = jiao_q;
  assign paid       = paid_q;

endmodule

// File: tb/tb_cola_buyer.sv
// Directed, table-driven bench for cola_buyer; each row is one clock cycle of stimulus and expected outputs.
module tb_cola_buyer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] yuan_cnt = 4'd0;
  logic [3:0] jiao_cnt = 4'd0;
  logic       out_cola = 1'b0;
  logic       out_coin = 1'b0;
  logic       in_yuan, in_jiao, busy, done, got_cola, got_change, err;
  logic [3:0] yuan_left, jiao_left;
  logic [2:0] paid;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        st;
    logic [3:0]  yc;
    logic [3:0]  jc;
    logic        cola;
    logic        coin;
    logic [17:0] expv;
  } vec_t;

  vec_t vecs[$];

  cola_buyer dut (
    .clk(clk), .rst(rst), .start(start), .yuan_cnt(yuan_cnt), .jiao_cnt(jiao_cnt),
    .out_cola(out_cola), .out_coin(out_coin), .in_yuan(in_yuan), .in_jiao(in_jiao),
    .busy(busy), .done(done), .got_cola(got_cola), .got_change(got_change), .err(err),
    .yuan_left(yuan_left), .jiao_left(jiao_left), .paid(paid)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {in_yuan, in_jiao, busy, done, got_cola, got_change, err, yuan_left, jiao_left, paid};
  endfunction

  // Row fields: start,yuan_cnt,jiao_cnt,out_cola,out_coin | in_yuan,in_jiao,busy,done,got_cola,got_change,err,yuan_left,jiao_left,paid
  task automatic r(input logic st, input logic [3:0] yc, input logic [3:0] jc, input logic cl, input logic cn,
                   input logic iy, input logic ij, input logic bz, input logic dn, input logic gc,
                   input logic gch, input logic er, input logic [3:0] yl, input logic [3:0] jl, input logic [2:0] pd);
    vec_t v;
    v.st = st; v.yc = yc; v.jc = jc; v.cola = cl; v.coin = cn;
    v.expv = {iy, ij, bz, dn, gc, gch, er, yl, jl, pd};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [17:0] expv);
    logic [17:0] act;
    act = outs();
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got iy/ij/busy/done/cola/chg/err=%b yl=%0d jl=%0d paid=%0d, want %b yl=%0d jl=%0d paid=%0d",
               nm, act[17:11], act[10:7], act[6:3], act[2:0], expv[17:11], expv[10:7], expv[6:3], expv[2:0]);
    end else begin
      $display("ok   %s: outputs=%h", nm, act);
    end
  endtask

  initial begin
`ifndef COLA_BUYER_DUAL_COIN_EN
    // Buy with 2 yuan + 1 jiao, drink delivered after the third coin.
    r(1,2,1,0,0, 0,0,0,0,0,0,0,0,0,0);
    r(0,0,0,0,0, 1,0,1,0,0,0,0,2,1,0);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,1,1,2);
    r(0,0,0,0,0, 1,0,1,0,0,0,0,1,1,2);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,0,1,4);
    r(0,0,0,0,0, 0,1,1,0,0,0,0,0,1,4);
    r(0,0,0,1,0, 0,0,1,0,0,0,0,0,0,5);
    r(0,0,0,0,0, 0,0,1,1,1,0,0,0,0,5);
    // Three yuan: overpay, drink plus change.
    r(1,3,0,0,0, 0,0,0,0,1,0,0,0,0,5);
    r(0,0,0,0,0, 1,0,1,0,0,0,0,3,0,0);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,2,0,2);
    r(0,0,0,0,0, 1,0,1,0,0,0,0,2,0,2);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,1,0,4);
    r(0,0,0,0,0, 1,0,1,0,0,0,0,1,0,4);
    r(0,0,0,1,1, 0,0,1,0,0,0,0,0,0,6);
    r(0,0,0,0,0, 0,0,1,1,1,1,0,0,0,6);
    // Insufficient funds: 1 yuan + 2 jiao, runs dry.
    r(1,1,2,0,0, 0,0,0,0,1,1,0,0,0,6);
    r(0,0,0,0,0, 1,0,1,0,0,0,0,1,2,0);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,0,2,2);
    r(0,0,0,0,0, 0,1,1,0,0,0,0,0,2,2);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,0,1,3);
    r(0,0,0,0,0, 0,1,1,0,0,0,0,0,1,3);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,0,0,4);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,0,0,4);
    r(0,0,0,0,0, 0,0,1,1,0,0,1,0,0,4);
    // Machine never dispenses; a start while busy is ignored.
    r(1,2,1,0,0, 0,0,0,0,0,0,1,0,0,4);
    r(0,0,0,0,0, 1,0,1,0,0,0,0,2,1,0);
    r(1,9,9,0,0, 0,0,1,0,0,0,0,1,1,2);
    r(0,0,0,0,0, 1,0,1,0,0,0,0,1,1,2);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,0,1,4);
    r(0,0,0,0,0, 0,1,1,0,0,0,0,0,1,4);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,0,0,5);
    r(0,0,0,0,0, 0,0,1,1,0,0,1,0,0,5);
    r(0,0,0,0,0, 0,0,0,0,0,0,1,0,0,5);
`else
    // Dual insertion first, then a single yuan.
    r(1,2,1,0,0, 0,0,0,0,0,0,0,0,0,0);
    r(0,0,0,0,0, 1,1,1,0,0,0,0,2,1,0);
    r(0,0,0,0,0, 0,0,1,0,0,0,0,1,0,3);
    r(0,0,0,0,0, 1,0,1,0,0,0,0,1,0,3);
    r(0,0,0,1,0, 0,0,1,0,0,0,0,0,0,5);
    r(0,0,0,0,0, 0,0,1,1,1,0,0,0,0,5);
    r(0,0,0,0,0, 0,0,0,0,1,0,0,0,0,5);
`endif

    // Reset state
    #3;
    chk("reset_hold", 18'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("after_release", 18'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; yuan_cnt = vecs[i].yc; jiao_cnt = vecs[i].jc;
      out_cola = vecs[i].cola; out_coin = vecs[i].coin;
      #1;
      chk($sformatf("row%0d", i), vecs[i].expv);
      @(posedge clk); #1;
    end

    // Abort mid-purchase with an asynchronous reset after the second coin.
    start = 1'b1; yuan_cnt = 4'd5; jiao_cnt = 4'd5; out_cola = 1'b0; out_coin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    total++;
    if (!busy) begin
      bad++;
      $display("FAIL abort_pre_busy: got busy=%b, want 1", busy);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("abort_immediate", 18'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_hold%0d", k), 18'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_reset_idle%0d", k), 18'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
